// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Feeds a processor's instruction input from a small loadable program store.
// Each instruction is held on `instr` for as many clocks as its opcode needs:
// LOAD (0000) is held LOAD_CYCLES clocks, ADD (0101) and XOR (0111) are held
// ALU_CYCLES clocks, and every other opcode is held one clock. The sequencer
// also supports a programmable length, loop mode and a stall input.
//
// Ports
//   clk        : single clock, rising edge
//   resetn     : asynchronous active-low reset
//   prog_we    : program store write strobe (accepted in IDLE only)
//   prog_addr  : program store write address
//   prog_data  : program store write data
//   prog_len   : instructions to run (0 or >DEPTH means DEPTH), sampled on start
//   start      : begin a run at address 0 (accepted in IDLE only)
//   loop_en    : wrap to address 0 at the end of the program instead of finishing
//   stall      : freeze issue state while high
//   instr      : registered instruction to the processor
//   pc         : address of the instruction currently on instr
//   step       : hold-cycle index within the current instruction
//   busy       : high while issuing
//   done       : one-cycle pulse when a run completes
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int              IW          = 16,
    parameter int              DEPTH       = 16,
    parameter int              AW          = $clog2(DEPTH),
    parameter int              LOAD_CYCLES = 2,
    parameter int              ALU_CYCLES  = 3,
    parameter logic [IW-1:0]   NOP_INSTR   = 16'b1111000000000000
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          loop_en,
    input  logic          stall,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] pc,
    output logic [1:0]    step,
    output logic          busy,
    output logic          done
);

    // The step counter is two bits wide, so hold counts are limited to 1..4.
    if (LOAD_CYCLES < 1 || LOAD_CYCLES > 4) begin : g_bad_load
        $error("instr_sequencer: LOAD_CYCLES must be in 1..4");
    end
    if (ALU_CYCLES < 1 || ALU_CYCLES > 4) begin : g_bad_alu
        $error("instr_sequencer: ALU_CYCLES must be in 1..4");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("instr_sequencer: DEPTH must be at least 2");
    end

    localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);
    localparam logic [1:0]  LOAD_LAST = 2'(LOAD_CYCLES - 1);
    localparam logic [1:0]  ALU_LAST  = 2'(ALU_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [1:0]      step_q, step_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic [AW:0]     len_q, len_d;

    // Program store: intentionally not reset so a program survives resetn.
    logic [IW-1:0]   mem_q [DEPTH];

    logic [3:0]      opcode;
    logic [1:0]      last_step;
    logic [AW:0]     len_sel;
    logic [IW-1:0]   mem0_next;
    logic [AW-1:0]   pc_inc;
    logic            pc_last;

    always_comb begin
        opcode = instr_q[IW-1 -: 4];
        case (opcode)
            4'b0000:          last_step = LOAD_LAST;
            4'b0101, 4'b0111: last_step = ALU_LAST;
            default:          last_step = 2'd0;
        endcase
    end

    assign len_sel   = (prog_len == '0 || prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
    // A write to address 0 on the start edge must be visible in the first instr.
    assign mem0_next = (prog_we && prog_addr == '0) ? prog_data : mem_q[0];
    assign pc_inc    = pc_q + 1'b1;
    assign pc_last   = ({1'b0, pc_q} == (len_q - 1'b1));

    always_ff @(posedge clk) begin
        if (prog_we && state_q == S_IDLE) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            step_q  <= '0;
            instr_q <= NOP_INSTR;
            len_q   <= DEPTH_LEN;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            step_q  <= step_d;
            instr_q <= instr_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        step_d  = step_q;
        instr_d = instr_q;
        len_d   = len_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    pc_d    = '0;
                    step_d  = '0;
                    instr_d = mem0_next;
                    len_d   = len_sel;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    if (step_q != last_step) begin
                        step_d = step_q + 2'd1;
                    end else if (!pc_last) begin
                        pc_d    = pc_inc;
                        step_d  = '0;
                        instr_d = mem_q[pc_inc];
                    end else if (loop_en) begin
                        pc_d    = '0;
                        step_d  = '0;
                        instr_d = mem_q[0];
                    end else begin
                        state_d = S_DONE;
                        pc_d    = '0;
                        step_d  = '0;
                        instr_d = NOP_INSTR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = '0;
                step_d  = '0;
                instr_d = NOP_INSTR;
            end
        endcase
    end

    assign instr = instr_q;
    assign pc    = pc_q;
    assign step  = step_q;
    assign busy  = (state_q == S_ISSUE);
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_sequencer.sv
`timescale 1ns/1ps
module tb_instr_sequencer;

    localparam int IW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [15:0] NOP = 16'hF000;

    logic          clk;
    logic          resetn;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [IW-1:0] prog_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          loop_en;
    logic          stall;
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic [1:0]    step;
    logic          busy;
    logic          done;

    instr_sequencer dut (
        .clk       (clk),
        .resetn    (resetn),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .start     (start),
        .loop_en   (loop_en),
        .stall     (stall),
        .instr     (instr),
        .pc        (pc),
        .step      (step),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] instr;
        logic [3:0]  pc;
        logic [1:0]  step;
        logic        dn;
    } exp_t;

    exp_t        expq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    logic [15:0] prog_m [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int nhold(input logic [15:0] ins);
        case (ins[15:12])
            4'b0000:          return 2;
            4'b0101, 4'b0111: return 3;
            default:          return 1;
        endcase
    endfunction

    // Monitor: every cycle the DUT presents busy or done, pop and compare.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && (busy || done)) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (expq.size() == 0) begin
                chk("unexpected_output", {14'b0, busy, done}, 32'h0);
            end else begin
                e = expq.pop_front();
                chk("instr", instr, e.instr);
                chk("busy", busy, !e.dn);
                chk("done", done, e.dn);
                if (!e.dn) begin
                    chk("pc", pc, e.pc);
                    chk("step", step, e.step);
                end
            end
        end
    end

    // Expected trace of a run: one entry per busy cycle (repeated while
    // stalled at unstalled cycle index stall_at), then an optional done entry.
    task automatic push_run(input int len, input int iters, input int stall_at,
                            input int stall_n, input int max_n, input bit with_done);
        int idx;
        int pushed;
        idx    = 0;
        pushed = 0;
        for (int it = 0; it < iters; it++) begin
            for (int a = 0; a < len; a++) begin
                for (int s = 0; s < nhold(prog_m[a]); s++) begin
                    for (int r = 0; r <= ((idx == stall_at) ? stall_n : 0); r++) begin
                        if (pushed < max_n) begin
                            expq.push_back('{instr: prog_m[a], pc: 4'(a), step: 2'(s), dn: 1'b0});
                            pushed++;
                        end
                    end
                    idx++;
                end
            end
        end
        if (with_done && pushed < max_n)
            expq.push_back('{instr: NOP, pc: 4'd0, step: 2'd0, dn: 1'b1});
    endtask

    task automatic write_mem(input int a, input logic [15:0] d);
        @(posedge clk); #1;
        prog_we   = 1'b1;
        prog_addr = 4'(a);
        prog_data = d;
        prog_m[a] = d;
        @(posedge clk); #1;
        prog_we   = 1'b0;
    endtask

    // Leaves the bench in busy cycle 0 of the new run.
    task automatic start_run(input logic [4:0] len, input bit le, input bit wr0, input logic [15:0] d0);
        @(posedge clk); #1;
        prog_len = len;
        loop_en  = le;
        start    = 1'b1;
        if (wr0) begin
            prog_we   = 1'b1;
            prog_addr = 4'd0;
            prog_data = d0;
        end
        @(posedge clk); #1;
        start   = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic run_cycles(input int n, input int sa, input int sn);
        for (int i = 0; i < n; i++) begin
            stall = (i >= sa && i < sa + sn);
            @(posedge clk); #1;
        end
        stall = 1'b0;
    endtask

    logic [15:0] base_prog [8];
    int b0, d0;

    initial begin
        base_prog = '{16'hF000, 16'h0103, 16'hF000, 16'h1510,
                      16'hF000, 16'h5510, 16'hF000, 16'h7000};
        resetn = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_len = '0; start = 1'b0; loop_en = 1'b0; stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) prog_m[i] = NOP;

        // Reset state, during and after reset
        repeat (3) @(posedge clk);
        #2;
        chk("rst_instr", instr, NOP);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pc", pc, 4'd0);
        chk("rst_step", step, 2'd0);
        chk("rst_done", done, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_instr", instr, NOP);
        chk("post_rst_busy", busy, 1'b0);

        // Stall while idle has no effect; stale store entries then overwritten
        for (int i = 0; i < DEPTH; i++) write_mem(i, NOP);
        for (int i = 0; i < 8; i++) write_mem(i, base_prog[i]);
        stall = 1'b1;
        @(posedge clk); #1;
        chk("idle_stall_busy", busy, 1'b0);
        stall = 1'b0;

        // Baseline program: 13 busy cycles then done
        b0 = busy_cnt; d0 = done_cnt;
        push_run(8, 1, -1, 0, 1000, 1'b1);
        start_run(5'd8, 1'b0, 1'b0, 16'h0);
        run_cycles(16, -1, 0);
        chk("base_busy_cycles", 32'(busy_cnt - b0), 32'd13);
        chk("base_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("base_queue_empty", 32'(expq.size()), 32'd0);

        // Stall two cycles during ADD step 1: 15 busy cycles
        b0 = busy_cnt; d0 = done_cnt;
        push_run(8, 1, 7, 2, 1000, 1'b1);
        start_run(5'd8, 1'b0, 1'b0, 16'h0);
        run_cycles(18, 7, 2);
        chk("stall_busy_cycles", 32'(busy_cnt - b0), 32'd15);
        chk("stall_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("stall_queue_empty", 32'(expq.size()), 32'd0);

        // Loop mode, with the address-0 write landing on the start edge
        write_mem(1, 16'h1510);
        prog_m[0] = 16'h0103;
        b0 = busy_cnt; d0 = done_cnt;
        push_run(2, 4, -1, 0, 1000, 1'b1);
        start_run(5'd2, 1'b1, 1'b1, 16'h0103);
        for (int i = 0; i < 15; i++) begin
            if (i == 9) loop_en = 1'b0;
            @(posedge clk); #1;
        end
        chk("loop_busy_cycles", 32'(busy_cnt - b0), 32'd12);
        chk("loop_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("loop_queue_empty", 32'(expq.size()), 32'd0);

        // prog_len=0 means DEPTH; start/prog_we mid-run are ignored
        for (int i = 0; i < DEPTH; i++) write_mem(i, NOP);
        b0 = busy_cnt;
        push_run(16, 1, -1, 0, 1000, 1'b1);
        start_run(5'd0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 19; i++) begin
            start     = (i == 5);
            prog_we   = (i == 5);
            prog_addr = 4'd3;
            prog_data = 16'h1234;
            @(posedge clk); #1;
        end
        start = 1'b0; prog_we = 1'b0;
        chk("len0_busy_cycles", 32'(busy_cnt - b0), 32'd16);
        chk("len0_queue_empty", 32'(expq.size()), 32'd0);

        // prog_len above DEPTH clamps; also shows the store kept F000 at 3
        b0 = busy_cnt;
        push_run(16, 1, -1, 0, 1000, 1'b1);
        start_run(5'd20, 1'b0, 1'b0, 16'h0);
        run_cycles(19, -1, 0);
        chk("clamp_busy_cycles", 32'(busy_cnt - b0), 32'd16);
        chk("clamp_queue_empty", 32'(expq.size()), 32'd0);

        // Reset during the ADD hold aborts with no done; store survives
        for (int i = 0; i < 8; i++) write_mem(i, base_prog[i]);
        d0 = done_cnt;
        push_run(8, 1, -1, 0, 7, 1'b0);
        start_run(5'd8, 1'b0, 1'b0, 16'h0);
        run_cycles(7, -1, 0);
        resetn = 1'b0;
        #1;
        chk("abort_instr", instr, NOP);
        chk("abort_busy", busy, 1'b0);
        chk("abort_pc", pc, 4'd0);
        chk("abort_step", step, 2'd0);
        chk("abort_done", done, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_queue_empty", 32'(expq.size()), 32'd0);

        b0 = busy_cnt; d0 = done_cnt;
        push_run(8, 1, -1, 0, 1000, 1'b1);
        start_run(5'd8, 1'b0, 1'b0, 16'h0);
        run_cycles(16, -1, 0);
        chk("replay_busy_cycles", 32'(busy_cnt - b0), 32'd13);
        chk("replay_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("replay_queue_empty", 32'(expq.size()), 32'd0);
        chk("final_idle_instr", instr, NOP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
